// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage. Owns the fetch PC (pc_f), drives the synchronous
//   instruction SRAM (one cycle read latency) and loads the IF/ID register
//   consumed by decode. Redirects from decode (branch / Jump / JumpV) take
//   effect after one delay slot; redirects that arrive while the pipe is
//   stalled are parked in a pending register and applied when it moves again.
//   An exception flush squashes IF/ID and restarts fetch at EXC_VECTOR.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   stall               hold pc_f and the IF/ID register
//   flush               squash IF/ID, refetch from EXC_VECTOR (beats stall)
//   branch/Jump/JumpV   redirect requests from decode, in that priority
//   branchAddr/jumpAddr/jrAddr   matching redirect targets
//   inst_sram_*         SRAM read port; wen and wdata are tied off
//   IF_ID_instr/PCout   fetched instruction (0 = bubble) and its PC
//   IF_ID_valid         IF_ID_instr is a real fetch
//   IF_ID_adel          fetch PC was not word aligned
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch,
    input  logic        Jump,
    input  logic        JumpV,
    input  logic [31:0] branchAddr,
    input  logic [31:0] jumpAddr,
    input  logic [31:0] jrAddr,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_PCout,
    output logic        IF_ID_valid,
    output logic        IF_ID_adel
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_f;
    logic [31:0] pend_target;
    logic        pend_valid;
    logic [31:0] req_pc;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        pc_f_adel;

    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;

    assign redirect  = branch | Jump | JumpV;
    assign pc_f_adel = (pc_f[1:0] != 2'b00);

    always_comb begin
        if (branch) begin
            redirect_target = branchAddr;
        end else if (Jump) begin
            redirect_target = jumpAddr;
        end else begin
            redirect_target = jrAddr;
        end
    end

    always_comb begin
        if (flush) begin
            req_pc = EXC_VECTOR;
        end else if (pend_valid) begin
            req_pc = pend_target;
        end else if (redirect) begin
            req_pc = redirect_target;
        end else begin
            req_pc = pc_f + 32'd4;
        end
    end

    // pc_f is always the address whose data is on inst_sram_rdata in RUN.
    // STALL re-presents pc_f so that the cycle after the stall releases
    // sees matching data; a flush outside RUN therefore goes through STALL
    // so EXC_VECTOR is presented before anything is loaded into IF/ID.
    always_comb begin
        state_next     = state;
        inst_sram_addr = pc_f;
        case (state)
            BOOT:    inst_sram_addr = RESET_VECTOR;
            RUN:     inst_sram_addr = req_pc;
            STALL:   inst_sram_addr = pc_f;
            default: inst_sram_addr = pc_f;
        endcase
        inst_sram_en = (inst_sram_addr[1:0] == 2'b00);
        if (flush) begin
            state_next = (state == RUN && !stall) ? RUN : STALL;
        end else begin
            case (state)
                BOOT:    state_next = RUN;
                RUN:     state_next = stall ? STALL : RUN;
                STALL:   state_next = stall ? STALL : RUN;
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // pc_f only advances out of RUN. A redirect seen while pc_f cannot move
    // (stalled, or the release cycle of STALL) is parked; a later one
    // overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f        <= RESET_VECTOR;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0000_0000;
        end else if (flush) begin
            pc_f       <= EXC_VECTOR;
            pend_valid <= 1'b0;
        end else if (state == RUN && !stall) begin
            pc_f       <= req_pc;
            pend_valid <= 1'b0;
        end else if (redirect && state != BOOT) begin
            pend_target <= redirect_target;
            pend_valid  <= 1'b1;
        end
    end

    // The release edge of STALL loads a bubble: decode consumes the held
    // instruction on that edge, and pc_f's data only arrives next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IF_ID_instr <= 32'h0000_0000;
            IF_ID_PCout <= 32'h0000_0000;
            IF_ID_valid <= 1'b0;
            IF_ID_adel  <= 1'b0;
        end else if (flush) begin
            IF_ID_instr <= 32'h0000_0000;
            IF_ID_valid <= 1'b0;
            IF_ID_adel  <= 1'b0;
        end else if (state == BOOT || (state == STALL && !stall)) begin
            IF_ID_instr <= 32'h0000_0000;
            IF_ID_valid <= 1'b0;
            IF_ID_adel  <= 1'b0;
        end else if (state == RUN && !stall) begin
            IF_ID_PCout <= pc_f;
            IF_ID_adel  <= pc_f_adel;
            IF_ID_valid <= 1'b1;
            IF_ID_instr <= pc_f_adel ? 32'h0000_0000 : inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//   Self-checking bench for if_stage. The bench plays both the instruction
//   SRAM (contents are a fixed hash of the address) and the decode stage.
//   The reference model is the architectural fetch stream: starting at a
//   vector, each instruction is followed by PC+4, except that a redirect
//   issued while decode holds instruction X sends the instruction after X's
//   delay slot to the target. Expected entries are queued as stimulus is
//   issued; a monitor pops one each time decode consumes a valid IF/ID entry
//   (IF_ID_valid with stall and flush low).
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RV = 32'hBFC0_0000;
    localparam logic [31:0] EV = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch;
    logic        Jump;
    logic        JumpV;
    logic [31:0] branchAddr;
    logic [31:0] jumpAddr;
    logic [31:0] jrAddr;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'h0;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_PCout;
    logic        IF_ID_valid;
    logic        IF_ID_adel;

    typedef struct {
        logic [31:0] pc;
        bit          delay;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] gen_pc;
    int          tests    = 0;
    int          fails    = 0;
    int          consumed = 0;

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .branch          (branch),
        .Jump            (Jump),
        .JumpV           (JumpV),
        .branchAddr      (branchAddr),
        .jumpAddr        (jumpAddr),
        .jrAddr          (jrAddr),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .IF_ID_instr     (IF_ID_instr),
        .IF_ID_PCout     (IF_ID_PCout),
        .IF_ID_valid     (IF_ID_valid),
        .IF_ID_adel      (IF_ID_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Synchronous SRAM; a disabled read returns garbage.
    always @(posedge clk) begin
        inst_sram_rdata <= inst_sram_en ? memf(inst_sram_addr) : $urandom();
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void top_up();
        ent_t e;
        while (exp_q.size() < 2) begin
            e.pc    = gen_pc;
            e.delay = 1'b0;
            exp_q.push_back(e);
            gen_pc  = gen_pc + 32'd4;
        end
    endfunction

    function automatic void model_restart(input logic [31:0] v);
        exp_q.delete();
        gen_pc = v;
        top_up();
    endfunction

    // Redirect for the held instruction exp_q[0]: its successor is the delay
    // slot, everything after that restarts at the target.
    function automatic void model_redirect(input logic [31:0] tgt);
        ent_t e;
        top_up();
        while (exp_q.size() > 2) begin
            void'(exp_q.pop_back());
        end
        e        = exp_q[1];
        e.delay  = 1'b1;
        exp_q[1] = e;
        gen_pc   = tgt;
    endfunction

    // kind: 0 none, 1 branch, 2 Jump, 3 JumpV, 4 all three (branch wins),
    // 5 Jump+JumpV (Jump wins). Called at posedge+1, returns at posedge+1
    // with the redirect lines, stall and flush released.
    task automatic apply_stimulus(input bit s, input bit f, input int kind, input logic [31:0] tgt);
        stall      = s;
        flush      = f;
        branch     = 1'b0;
        Jump       = 1'b0;
        JumpV      = 1'b0;
        branchAddr = $urandom();
        jumpAddr   = $urandom();
        jrAddr     = $urandom();
        if (f) begin
            model_restart(EV);
        end else if (kind != 0 && IF_ID_valid && exp_q.size() > 0 && !exp_q[0].delay) begin
            case (kind)
                1: begin branch = 1'b1; branchAddr = tgt; end
                2: begin Jump = 1'b1; jumpAddr = tgt; end
                3: begin JumpV = 1'b1; jrAddr = tgt; end
                4: begin branch = 1'b1; Jump = 1'b1; JumpV = 1'b1; branchAddr = tgt; end
                default: begin Jump = 1'b1; JumpV = 1'b1; jumpAddr = tgt; end
            endcase
            model_redirect(tgt);
        end
        top_up();
        @(posedge clk);
        #1;
        stall  = 1'b0;
        flush  = 1'b0;
        branch = 1'b0;
        Jump   = 1'b0;
        JumpV  = 1'b0;
    endtask

    // Idle until decode holds a valid, non-delay-slot instruction.
    task automatic wait_holdable(input string name);
        int n;
        n = 0;
        while (!(IF_ID_valid && exp_q.size() > 0 && !exp_q[0].delay) && n < 20) begin
            apply_stimulus(1'b0, 1'b0, 0, 32'h0);
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s: no holdable instruction within 20 cycles", name);
        end
    endtask

    // Monitor: compare every consumed IF/ID entry against the model stream.
    initial begin
        ent_t        e;
        logic [31:0] e_instr;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (IF_ID_valid && !stall && !flush) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_fetch: got PC %h, expected none", IF_ID_PCout);
                    end else begin
                        e       = exp_q.pop_front();
                        e_instr = (e.pc[1:0] != 2'b00) ? 32'h0 : memf(e.pc);
                        consumed++;
                        check_output("if_id_pc", IF_ID_PCout, e.pc);
                        check_output("if_id_instr", IF_ID_instr, e_instr);
                        check_output("if_id_adel", {31'b0, IF_ID_adel}, {31'b0, (e.pc[1:0] != 2'b00)});
                    end
                end
                if (!IF_ID_valid) begin
                    check_output("bubble_instr", IF_ID_instr, 32'h0);
                end
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        int          kind;
        int          n;
        rst        = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        branch     = 1'b0;
        Jump       = 1'b0;
        JumpV      = 1'b0;
        branchAddr = 32'h0;
        jumpAddr   = 32'h0;
        jrAddr     = 32'h0;
        model_restart(RV);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid", {31'b0, IF_ID_valid}, 32'h0);
        check_output("rst_instr", IF_ID_instr, 32'h0);
        check_output("rst_pcout", IF_ID_PCout, 32'h0);
        check_output("rst_adel", {31'b0, IF_ID_adel}, 32'h0);
        check_output("rst_addr", inst_sram_addr, RV);
        check_output("rst_en", {31'b0, inst_sram_en}, 32'h1);
        check_output("rst_wen", {28'b0, inst_sram_wen}, 32'h0);
        check_output("rst_wdata", inst_sram_wdata, 32'h0);
        rst = 1'b0;
        #1;
        check_output("boot_addr", inst_sram_addr, RV);

        // Branch with delay slot at BFC00008
        n = 0;
        while (!(IF_ID_valid && exp_q[0].pc == RV + 32'd8) && n < 20) begin
            apply_stimulus(1'b0, 1'b0, 0, 32'h0);
            n++;
        end
        check_output("reach_bfc00008", IF_ID_PCout, RV + 32'd8);
        apply_stimulus(1'b0, 1'b0, 1, 32'hBFC0_0100);
        repeat (4) apply_stimulus(1'b0, 1'b0, 0, 32'h0);

        // Three-cycle stall, Jump in the second stalled cycle
        wait_holdable("stall_jump");
        apply_stimulus(1'b1, 1'b0, 0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 2, 32'hBFC0_0200);
        apply_stimulus(1'b1, 1'b0, 0, 32'h0);
        repeat (5) apply_stimulus(1'b0, 1'b0, 0, 32'h0);

        // Flush together with stall
        apply_stimulus(1'b1, 1'b1, 0, 32'h0);
        #1;
        check_output("flush_valid", {31'b0, IF_ID_valid}, 32'h0);
        check_output("flush_instr", IF_ID_instr, 32'h0);
        repeat (5) apply_stimulus(1'b0, 1'b0, 0, 32'h0);

        // JumpV to a misaligned target
        wait_holdable("jumpv_misaligned");
        apply_stimulus(1'b0, 1'b0, 3, 32'hBFC0_0042);
        #1;
        check_output("misaligned_en", {31'b0, inst_sram_en}, 32'h0);
        repeat (3) apply_stimulus(1'b0, 1'b0, 0, 32'h0);
        wait_holdable("recover");
        apply_stimulus(1'b0, 1'b0, 2, 32'hBFC0_0300);
        repeat (4) apply_stimulus(1'b0, 1'b0, 0, 32'h0);

        // Reset while a redirect is pending
        wait_holdable("reset_pending");
        apply_stimulus(1'b1, 1'b0, 2, 32'hBFC0_0200);
        rst = 1'b1;
        model_restart(RV);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("rerst_addr", inst_sram_addr, RV);
        repeat (6) apply_stimulus(1'b0, 1'b0, 0, 32'h0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            kind = ($urandom_range(0, 99) < 20) ? int'($urandom_range(1, 5)) : 0;
            tgt  = RV + {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            if (kind == 3 && $urandom_range(0, 3) == 0) begin
                tgt[1:0] = 2'($urandom_range(1, 3));
            end
            apply_stimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3, kind, tgt);
        end
        repeat (4) apply_stimulus(1'b0, 1'b0, 0, 32'h0);

        check_output("progress", {31'b0, (consumed >= 300)}, 32'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
